// File: rtl/mips_defs_pkg.sv
// Shared core definitions: datapath widths, reset PC, bubble encoding and
// the fetch-stage state type.
package mips_defs_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } if_state_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus: one request in flight,
// req/gnt handshake for the address, rvalid qualifies returned data.
interface if_fetch_stage_if;
  import mips_defs_pkg::*;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              gnt;
  logic              rvalid;
  logic [INST_W-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Priority: rst > flush > stall > load > bubble.
module if_id_reg
  import mips_defs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic [INST_W-1:0] load_inst,
  output logic              valid,
  output logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst
);

  // Register the pc/inst pair, holding under stall and inserting a bubble otherwise.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= NOP_INST;
    end else if (stall) begin
      valid <= valid;
      pc    <= pc;
      inst  <= inst;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      inst  <= load_inst;
    end else begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= NOP_INST;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request,
// parks a response in a one-entry skid while decode stalls, and feeds IF/ID.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  REQ   | request asserted at pc, waiting for gnt
//  WAIT  | request accepted, waiting for rvalid
//  HOLD  | response parked in skid because decode is stalled
//  DROP  | squashed request still in flight, its response will be discarded
module if_fetch_stage
  import mips_defs_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic [ADDR_W-1:0]    flush_pc_i,
  if_fetch_stage_if.master     imem,
  output logic                 if_valid_o,
  output logic [ADDR_W-1:0]    if_pc_o,
  output logic [INST_W-1:0]    if_inst_o
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  if_state_t         state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] req_pc, req_pc_nxt;
  logic [ADDR_W-1:0] skid_pc, skid_pc_nxt;
  logic [INST_W-1:0] skid_inst, skid_inst_nxt;
  logic              skid_valid, skid_valid_nxt;
  logic              load;
  logic [ADDR_W-1:0] load_pc;
  logic [INST_W-1:0] load_inst;

  // Request is held low while in reset so the first req appears the cycle after release.
  assign imem.req  = (state == REQ) && !rst;
  assign imem.addr = pc;

  // State, PC and skid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= REQ;
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      skid_pc    <= '0;
      skid_inst  <= NOP_INST;
      skid_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      req_pc     <= req_pc_nxt;
      skid_pc    <= skid_pc_nxt;
      skid_inst  <= skid_inst_nxt;
      skid_valid <= skid_valid_nxt;
    end
  end

  // Next-state, PC update and IF/ID load selection; a flush overrides all of it.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    req_pc_nxt     = req_pc;
    skid_pc_nxt    = skid_pc;
    skid_inst_nxt  = skid_inst;
    skid_valid_nxt = skid_valid;
    load           = 1'b0;
    load_pc        = req_pc;
    load_inst      = imem.rdata;

    unique case (state)
      REQ: begin
        if (imem.gnt) begin
          req_pc_nxt = pc;
          state_nxt  = WAIT;
        end
      end
      WAIT: begin
        if (imem.rvalid) begin
          pc_nxt = req_pc + STEP;
          if (stall_i) begin
            skid_pc_nxt    = req_pc;
            skid_inst_nxt  = imem.rdata;
            skid_valid_nxt = 1'b1;
            state_nxt      = HOLD;
          end else begin
            load      = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      HOLD: begin
        if (!stall_i) begin
          load           = 1'b1;
          load_pc        = skid_pc;
          load_inst      = skid_inst;
          skid_valid_nxt = 1'b0;
          state_nxt      = REQ;
        end
      end
      DROP: begin
        if (imem.rvalid) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase

    if (flush_i) begin
      pc_nxt         = flush_pc_i;
      skid_valid_nxt = 1'b0;
      load           = 1'b0;
      unique case (state)
        REQ:     state_nxt = imem.gnt    ? DROP : REQ;
        WAIT:    state_nxt = imem.rvalid ? REQ  : DROP;
        HOLD:    state_nxt = REQ;
        // A response landing in the flush cycle retires the squashed request;
        // staying in DROP would then wait for a response that never comes.
        DROP:    state_nxt = imem.rvalid ? REQ  : DROP;
        default: state_nxt = REQ;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_i),
    .stall     (stall_i),
    .load      (load),
    .load_pc   (load_pc),
    .load_inst (load_inst),
    .valid     (if_valid_o),
    .pc        (if_pc_o),
    .inst      (if_inst_o)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: randomized memory slave and stall/flush stimulus,
// a program-order reference stream of expected PCs, and a monitor that
// compares every IF/ID delivery and the bus protocol against it.
module tb_if_fetch_stage;
  import mips_defs_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  if_fetch_stage_if imem_bus ();

  if_fetch_stage #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall),
    .flush_i    (flush),
    .flush_pc_i (flush_pc),
    .imem       (imem_bus),
    .if_valid_o (if_valid),
    .if_pc_o    (if_pc),
    .if_inst_o  (if_inst)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int delivered = 0;

  // expected program-order PC stream from the last reset/redirect
  logic [31:0] exp_q[$];

  // memory slave state
  int          gnt_mode = 0;
  int          lat_max = 0;
  int          gnt_wait = 0;
  bit          out_valid = 0;
  bit          out_drop = 0;
  int          out_lat = 0;
  logic [31:0] out_addr = 0;
  bit          held = 0;

  // snapshot of everything the DUT sees at the coming edge
  bit          p_rst = 1, p_stall = 0, p_flush = 0, p_req = 0, p_gnt = 0, p_rvalid = 0;
  bit          p_out = 0, p_held = 0;
  logic [31:0] p_addr = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic restart_exp(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back(start + 32'(i * 4));
  endtask

  // One clock of stimulus: core controls, memory response, then the
  // reference bookkeeping for what the coming edge does.
  task automatic step(input bit r, input bit s, input bit f, input logic [31:0] fp);
    @(negedge clk);
    rst = r; stall = s; flush = f; flush_pc = fp;
    #1;
    imem_bus.gnt    = 1'b0;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = $urandom;
    if (!r) begin
      if (out_valid) begin
        if (out_lat == 0) begin
          imem_bus.rvalid = 1'b1;
          imem_bus.rdata  = mem_word(out_addr);
        end
      end else if (imem_bus.req) begin
        case (gnt_mode)
          0:       imem_bus.gnt = 1'b1;
          1:       imem_bus.gnt = (gnt_wait >= 4);
          default: imem_bus.gnt = ($urandom_range(0, 2) == 0);
        endcase
        if (!imem_bus.gnt) gnt_wait++;
      end
    end
    #1;
    p_rst = r; p_stall = s; p_flush = f;
    p_req = imem_bus.req; p_addr = imem_bus.addr;
    p_gnt = imem_bus.gnt; p_rvalid = imem_bus.rvalid;
    p_out = out_valid; p_held = held;
    if (r) begin
      out_valid = 0; held = 0; gnt_wait = 0;
      restart_exp(RST_PC);
    end else begin
      if (held && (!s || f)) held = 0;
      if (p_rvalid) begin
        if (!out_drop && !f && s) held = 1;
        out_valid = 0;
      end else if (out_valid && out_lat > 0) begin
        out_lat--;
      end
      if (p_req && p_gnt) begin
        out_valid = 1; out_drop = 0; out_addr = p_addr;
        out_lat = $urandom_range(0, lat_max); gnt_wait = 0;
      end
      if (f) begin
        out_drop = 1;
        restart_exp(fp);
      end
    end
  endtask

  // monitor: model of IF/ID contents and previous-edge snapshot
  bit          m_valid = 0;
  logic [31:0] m_pc = 0, m_inst = 0;
  int          idle = 0;
  int          idle_max = 40;
  bit          q_req = 0, q_gnt = 0, q_flush = 0, q_rst = 1;
  logic [31:0] q_addr = 0;

  always @(posedge clk) begin
    logic [31:0] e;
    #1;
    if (p_rst) begin
      chk("rst_valid", 32'(if_valid), 32'h0);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_inst", if_inst, 32'h0);
      chk("rst_req", 32'(imem_bus.req), 32'h0);
      chk("rst_addr", imem_bus.addr, RST_PC);
      m_valid = 0; m_pc = 0; m_inst = 0; idle = 0;
    end else begin
      chk("one_outstanding", 32'(p_req && p_out), 32'h0);
      chk("no_req_in_hold", 32'(p_req && p_held), 32'h0);
      if (q_req && !q_gnt && !q_flush && !q_rst) begin
        chk("req_held", 32'(p_req), 32'h1);
        chk("addr_stable", p_addr, q_addr);
      end
      if (p_flush) begin
        chk("flush_valid", 32'(if_valid), 32'h0);
        chk("flush_inst", if_inst, 32'h0);
        m_valid = 0; m_pc = 0; m_inst = 0; idle = 0;
      end else if (p_stall) begin
        chk("stall_valid", 32'(if_valid), 32'(m_valid));
        chk("stall_pc", if_pc, m_pc);
        chk("stall_inst", if_inst, m_inst);
      end else begin
        if (p_held) chk("skid_release", 32'(if_valid), 32'h1);
        if (if_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty actual_pc=%h required=none", if_pc);
          end else begin
            e = exp_q.pop_front();
            chk("deliver_pc", if_pc, e);
            chk("deliver_inst", if_inst, mem_word(e));
            m_valid = 1; m_pc = e; m_inst = mem_word(e);
          end
          delivered++;
          idle = 0;
        end else begin
          chk("bubble_pc", if_pc, 32'h0);
          chk("bubble_inst", if_inst, 32'h0);
          m_valid = 0; m_pc = 0; m_inst = 0;
          idle++;
          if (idle > idle_max) begin
            checks++; errors++;
            $display("FAIL fetch_progress actual_idle=%0d required_max=%0d", idle, idle_max);
            idle = 0;
          end
        end
      end
    end
    q_req = p_req; q_gnt = p_gnt; q_flush = p_flush; q_rst = p_rst; q_addr = p_addr;
  end

  initial begin
    bit          f;
    logic [31:0] fp;
    imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.rdata = 32'h0;
    restart_exp(RST_PC);
    repeat (3) step(1, 0, 0, 0);

    // zero-wait memory, no stall: one instruction every second cycle
    gnt_mode = 0; lat_max = 0; idle_max = 1;
    repeat (40) step(0, 0, 0, 0);
    idle_max = 40;

    // random grant/latency with stalls (skid path)
    gnt_mode = 2; lat_max = 3;
    for (int i = 0; i < 600; i++) step(0, $urandom_range(0, 99) < 30, 0, 0);

    // grant delayed four cycles
    gnt_mode = 1; lat_max = 1;
    repeat (80) step(0, 0, 0, 0);

    // redirect to the top of the address space: next fetch wraps to 0
    gnt_mode = 0; lat_max = 0;
    step(0, 0, 1, 32'hFFFF_FFFC);
    repeat (20) step(0, 0, 0, 0);

    // flush while a request is outstanding, late response must be dropped
    lat_max = 3;
    for (int k = 0; k < 50 && !out_valid; k++) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_0100);
    repeat (20) step(0, 0, 0, 0);

    // flush and stall together on a valid IF/ID
    for (int k = 0; k < 50 && !if_valid; k++) step(0, 0, 0, 0);
    step(0, 1, 1, 32'h0000_0200);
    repeat (20) step(0, 0, 0, 0);

    // random mix including flushes
    gnt_mode = 2; lat_max = 2;
    for (int i = 0; i < 1500; i++) begin
      f  = ($urandom_range(0, 99) < 4);
      fp = 32'($urandom_range(0, 1023)) << 2;
      step(0, $urandom_range(0, 99) < 30, f, fp);
    end

    // reset while a response sits in the skid
    gnt_mode = 0; lat_max = 0;
    repeat (10) step(0, 1, 0, 0);
    repeat (2) step(1, 1, 0, 0);
    repeat (30) step(0, 0, 0, 0);

    if (delivered < 100) begin
      checks++; errors++;
      $display("FAIL delivered_count actual=%0d required_min=100", delivered);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
